// File: rtl/aes_encrypt_scheduler_if.sv
// aes_encrypt_scheduler_if: requester-side block/ciphertext handshakes shared by all requesters
interface aes_encrypt_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][127:0] req_data;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [127:0]           rsp_data;
  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/aes_encrypt_scheduler.sv
// aes_encrypt_scheduler: round-robin sharing of one fixed-latency AES core with tag steering and key-swap sequencing
module aes_encrypt_scheduler #(
  parameter int NREQ    = 4,
  parameter int KEYLEN  = 128,
  parameter int LATENCY = (KEYLEN/32+5)*4+1,
  parameter int MAX_OUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_encrypt_scheduler_if.slave bus,
  output logic                  core_valid_in,
  input  logic                  core_ready_in,
  output logic [127:0]          core_plaintext,
  input  logic                  core_valid_out,
  output logic                  core_en,
  input  logic [127:0]          core_ciphertext,
  input  logic                  key_upd_req,
  output logic                  key_load,
  output logic                  key_upd_ack,
  output logic                  busy,
  output logic                  err_underflow
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_OUT+1);
  localparam int PW = $clog2(LATENCY);
  localparam int FW = $clog2(LATENCY+1);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, grant, g_lo, g_hi, head;
  logic            any_hi, any_elig, issue, pop, empty, full, armed, trig, run;
  logic [NREQ-1:0] elig;
  logic [CW-1:0]   out_cnt [NREQ];
  logic [IW-1:0]   tag_mem [LATENCY];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [FW-1:0]   fifo_cnt;

  // The core is in-order with fixed depth, so the FIFO occupancy is the total in flight
  assign empty = fifo_cnt == '0;
  assign full  = fifo_cnt == FW'(LATENCY);
  assign busy  = !empty;
  assign head  = tag_mem[rd_ptr];

  assign core_en      = !(core_valid_out && !empty && !bus.rsp_ready[head]);
  assign pop          = core_valid_out && core_en && !empty;
  assign bus.rsp_data = core_ciphertext;

  always_comb begin
    bus.rsp_valid       = '0;
    bus.rsp_valid[head] = core_valid_out && !empty;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      elig[i] = run && bus.req_valid[i] && out_cnt[i] < CW'(MAX_OUT);
  end

  // Lowest eligible index at or above the pointer wins, else lowest eligible overall
  always_comb begin
    g_lo   = '0;
    g_hi   = '0;
    any_hi = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (elig[i]) g_lo = IW'(i);
      if (elig[i] && IW'(i) >= rr_ptr) begin
        g_hi   = IW'(i);
        any_hi = 1'b1;
      end
    end
    grant = any_hi ? g_hi : g_lo;
  end

  assign any_elig       = |elig;
  assign core_valid_in  = any_elig;
  assign issue          = any_elig && core_ready_in && core_en;
  assign core_plaintext = any_elig ? bus.req_data[grant] : '0;

  always_comb begin
    bus.req_ready        = '0;
    bus.req_ready[grant] = any_elig && core_ready_in && core_en;
  end

  // A held key_upd_req must drop for a cycle before it can start another swap
  assign trig = key_upd_req && armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state == RUN   ? (trig ? DRAIN : RUN) :
               state == DRAIN ? (empty && !issue ? LOAD : DRAIN) : RUN;
  end

  always_comb begin
    run         = state == RUN;
    key_load    = state == LOAD;
    key_upd_ack = state == LOAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      armed         <= 1'b1;
      err_underflow <= 1'b0;
      for (int i = 0; i < NREQ; i++) out_cnt[i] <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= grant == IW'(NREQ-1) ? '0 : grant + 1'b1;
        wr_ptr <= wr_ptr == PW'(LATENCY-1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PW'(LATENCY-1) ? '0 : rd_ptr + 1'b1;
      fifo_cnt      <= fifo_cnt + FW'(issue) - FW'(pop);
      armed         <= !key_upd_req || (armed && !trig);
      err_underflow <= err_underflow || (core_valid_out && empty);
      for (int i = 0; i < NREQ; i++)
        out_cnt[i] <= out_cnt[i] + CW'(issue && grant == IW'(i)) - CW'(pop && head == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= grant;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(issue && full));

endmodule
